// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (types, constants and one helper only).
// Backpressure: n/a.
//
// Contents: FSM state encodings, NOP word, default reset vector, the
// packed word carried from fetch into the IF/ID register, and the
// sequential-PC helper (modulo 2^32).
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    FETCH_S   = 2'd0,
    HOLD_S    = 2'd1,
    DISCARD_S = 2'd2,
    FAULT_S   = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INST     = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam logic [31:0] INST_BYTES   = 32'd4;

  // One fetched word on its way into IF/ID.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } fetch_word_t;

  // Next sequential fetch address; wraps naturally at 2^32.
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + INST_BYTES;
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry skid buffer plus IF/ID pipeline register.
// Latency: a delivered word reaches IF/ID on the next edge; a buffered word one edge after stall drops.
// Backpressure: stall freezes IF/ID; a word arriving under stall is parked in the buffer.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   stall, flush  hazard stall (hold IF/ID), flush (kill IF/ID and buffer)
//   inVld, inWord word delivered by the fetch logic this cycle
//   ifidValid     IF/ID holds a real instruction
//   ifidWord      IF/ID contents {pc, inst, adel}
module fetch_skid_buffer
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        inVld,
  input  fetch_word_t inWord,
  output logic        ifidValid,
  output fetch_word_t ifidWord
);

  logic        bufValid;
  fetch_word_t bufWord;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bufValid  <= 1'b0;
      bufWord   <= '0;
      ifidValid <= 1'b0;
      ifidWord  <= '0;
    end else if (flush) begin
      bufValid  <= 1'b0;
      ifidValid <= 1'b0;
    end else if (stall) begin
      // IF/ID frozen; park whatever memory handed back this cycle.
      if (inVld) begin
        bufWord  <= inWord;
        bufValid <= 1'b1;
      end
    end else if (bufValid) begin
      // Fetch issues no request while a word is parked, so the buffer
      // never competes with a fresh delivery here.
      ifidWord  <= bufWord;
      ifidValid <= 1'b1;
      bufValid  <= 1'b0;
    end else if (inVld) begin
      ifidWord  <= inWord;
      ifidValid <= 1'b1;
    end else begin
      // Bubble: pc/inst hold for debug visibility, error flag clears.
      ifidValid     <= 1'b0;
      ifidWord.adel <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues word fetches, feeds IF/ID to decode.
// Latency: instDataOk in cycle N gives ifidValid with that word in N+1; one word per cycle at zero wait.
// Backpressure: stall parks a returning word and stops requesting until stall drops.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned fetch raises ifidAdel and parks in FAULT).
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   stall                     hazard unit hold of IF/ID
//   redirectValid/redirectPc  taken branch/jump from decode (delayed-branch)
//   flushValid/flushPc        exception/eret restart, highest priority
//   instReq/instAddr          request to instruction memory
//   instDataOk/instRdata      completion and returned word
//   ifidValid/ifidPc/ifidInst IF/ID register presented to decode
//   ifidAdel                  fetch address error flag
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirectValid,
  input  logic [31:0] redirectPc,
  input  logic        flushValid,
  input  logic [31:0] flushPc,
  output logic        instReq,
  output logic [31:0] instAddr,
  input  logic        instDataOk,
  input  logic [31:0] instRdata,
  output logic        ifidValid,
  output logic [31:0] ifidPc,
  output logic [31:0] ifidInst,
  output logic        ifidAdel
);

  fetch_state_t state, stateNext;
  logic [31:0]  pcReg, reqAddr, pendPc, nextPc;
  logic         pendValid;
  logic         misaligned, fetchAct, reqOut, wordOk, faultWord, inVld;
  fetch_word_t  inWord, ifidWord;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = (reqAddr[1:0] != 2'b00);
  assign faultWord  = (state == FETCH_S) && misaligned && !stall;
`else
  assign misaligned = 1'b0;
  assign faultWord  = 1'b0;
`endif

  // A request is live in FETCH (unless the address faulted) and in DISCARD.
  assign fetchAct = (state == FETCH_S) && !misaligned;
  assign reqOut   = fetchAct || (state == DISCARD_S);
  assign wordOk   = fetchAct && instDataOk;

  // A redirect in the completion cycle beats one latched earlier.
  assign nextPc = redirectValid ? redirectPc :
                  pendValid     ? pendPc     : seq_pc(reqAddr);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH_S;
    else     state <= stateNext;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    stateNext = state;
    if (flushValid) begin
      // Memory cannot cancel, so an unanswered request must be drained.
      stateNext = (reqOut && !instDataOk) ? DISCARD_S : FETCH_S;
    end else begin
      case (state)
        FETCH_S: begin
          if (wordOk && stall) stateNext = HOLD_S;
`ifdef FETCH_ALIGN_CHECK_EN
          if (misaligned && !stall) stateNext = FAULT_S;
`endif
        end
        HOLD_S:    if (!stall)     stateNext = FETCH_S;
        DISCARD_S: if (instDataOk) stateNext = FETCH_S;
        default:   stateNext = state;  // FAULT waits for a flush
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    instReq = reqOut && !rst;
`ifdef FETCH_ALIGN_CHECK_EN
    instAddr = reqAddr;
`else
    instAddr = {reqAddr[31:2], 2'b00};
`endif
  end

  // ---------------- PC, request address, redirect latch ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcReg     <= RESET_PC;
      reqAddr   <= RESET_PC;
      pendValid <= 1'b0;
      pendPc    <= '0;
    end else if (flushValid) begin
      pendValid <= 1'b0;
      pcReg     <= flushPc;
      // If we must drain, reqAddr stays on the abandoned address.
      if (!(reqOut && !instDataOk)) reqAddr <= flushPc;
    end else begin
      case (state)
        FETCH_S: begin
          if (wordOk) begin
            reqAddr   <= nextPc;
            pcReg     <= nextPc;
            pendValid <= 1'b0;
          end else if (redirectValid) begin
            // The in-flight word is the delay slot; remember the target.
            pendValid <= 1'b1;
            pendPc    <= redirectPc;
          end
        end
        HOLD_S: begin
          if (redirectValid) pcReg <= redirectPc;
          if (!stall) reqAddr <= redirectValid ? redirectPc : pcReg;
        end
        DISCARD_S: begin
          if (instDataOk) reqAddr <= pcReg;
        end
        default: ;
      endcase
    end
  end

  // ---------------- IF/ID ----------------
  assign inVld  = !flushValid && (wordOk || faultWord);
  assign inWord = '{pc:   reqAddr,
                    inst: misaligned ? NOP_INST : instRdata,
                    adel: misaligned};

  fetch_skid_buffer u_skid (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flushValid),
    .inVld     (inVld),
    .inWord    (inWord),
    .ifidValid (ifidValid),
    .ifidWord  (ifidWord)
  );

  assign ifidPc   = ifidWord.pc;
  assign ifidInst = ifidWord.inst;
  // Without the alignment check the adel source is tied low, so this is constant 0.
  assign ifidAdel = ifidWord.adel;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage with integrated IF/ID pipeline register, sitting directly upstream of `main_decoder`. It owns the PC and issues word fetches to instruction memory over a request/data-ok handshake. It honours delayed-branch redirects from decode, stalls from the hazard unit and flushes from exception logic. It presents `{ifidValid, ifidPc, ifidInst}` to decode, which slices `op`, `funct` and `rt` from `ifidInst`.

## Interface
- `RESET_PC`, default `32'hBFC0_0000`: first fetch address after reset.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hazard unit: hold IF/ID contents and do not accept a new word into IF/ID.
- `redirectValid`  in  1  one-cycle pulse from decode: branch/jump taken.
- `redirectPc`  in  32  target, valid with `redirectValid`.
- `flushValid`  in  1  exception/eret flush, highest priority.
- `flushPc`  in  32  restart address, valid with `flushValid`.
- `instReq`  out  1  fetch request to instruction memory.
- `instAddr`  out  32  fetch address, stable while `instReq` is high and `instDataOk` is low.
- `instDataOk`  in  1  memory returns `instRdata` this cycle and completes the request.
- `instRdata`  in  32  fetched word.
- `ifidValid`  out  1  IF/ID holds a real instruction.
- `ifidPc`  out  32  PC of `ifidInst`.
- `ifidInst`  out  32  instruction word to decode.
- `ifidAdel`  out  1  fetch address error; present only with the macro, otherwise tied 0.

## Operation
- Registers:
  - `pcReg`: next fetch address.
  - `reqAddr`: address of the outstanding request.
  - `pendValid` and `pendPc`: latched redirect.
  - Skid buffer: `bufInst`, `bufPc`.
  - IF/ID registers.
  - `state`.
- States are FETCH, HOLD, DISCARD, plus FAULT under the macro.
- `instReq` = `(state==FETCH || state==DISCARD) && !rst`. `instAddr` = `reqAddr`.
- FETCH, on `instDataOk`:
  - Next PC = `redirectValid ? redirectPc : pendValid ? pendPc : reqAddr+4`. It is loaded into `reqAddr` and `pcReg`, and `pendValid` is cleared.
  - If `!stall`: IF/ID ← `{1, reqAddr, instRdata}`, and the stage stays in FETCH, issuing back-to-back requests.
  - If `stall`: buffer ← `{reqAddr, instRdata}`, then go to HOLD.
- FETCH, without `instDataOk`: `redirectValid` sets `pendValid`/`pendPc`. The in-flight word is the delay slot and is kept.
- HOLD: `instReq`=0.
  - `redirectValid` overwrites `pcReg` directly.
  - When `!stall`: IF/ID ← buffer, `reqAddr` ← `pcReg`, go to FETCH.
- DISCARD: keep the abandoned request alive at the old `reqAddr`. On `instDataOk`, drop the data, set `reqAddr` ← `pcReg`, go to FETCH.
- IF/ID update when `!stall` and no word is delivered this cycle: `ifidValid` ← 0 (bubble), while `ifidPc`/`ifidInst` hold.
- `stall` overrides all IF/ID loads.
- `flushValid` (any state):
  - `ifidValid` ← 0, buffer invalidated, `pendValid` ← 0, `pcReg` ← `flushPc`.
  - Next state is DISCARD if a request is outstanding and `instDataOk`=0 this cycle.
  - Otherwise next state is FETCH with `reqAddr` ← `flushPc`. Data arriving in the flush cycle is dropped.
- Priority: flush > stall > redirect > sequential.
- PC arithmetic is modulo 2^32; `32'hFFFF_FFFC`+4 wraps to 0.

## Timing
- Reset values:
  - `state`=FETCH, `reqAddr`=`pcReg`=`RESET_PC`.
  - `pendValid`=0, `ifidValid`=0, `ifidPc`=0, `ifidInst`=0, `ifidAdel`=0.
  - `instReq`=0 while `rst` is high, and 1 in the first cycle after deassertion.
- Latency: `instDataOk` in cycle N gives `ifidValid`=1 with that word in N+1. The next request is issued in N+1.
- Zero-wait memory (`instDataOk` every cycle) sustains one instruction per cycle.
- Redirect in cycle N with the delay slot completing in N: the target is requested in N+1.
- Redirect in the same cycle as a flush is ignored.
- Reset asserted mid-request abandons it. Memory must tolerate an unanswered request across reset.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - In FETCH with `reqAddr[1:0]!=0`, no request is issued (`instReq`=0).
  - IF/ID ← `{1, reqAddr, 32'h0}` with `ifidAdel`=1 (subject to `stall`), then go to FAULT.
  - FAULT idles until `flushValid`.
- `FETCH_ALIGN_CHECK_EN` undefined: `instAddr` = `{reqAddr[31:2],2'b00}`, `ifidAdel` is constant 0, and the FAULT state is absent.

## Structure
- `defines.vh` gains the state encodings (`FETCH_S`, `HOLD_S`, `DISCARD_S`, `FAULT_S`), `NOP_INST` = `32'h0` and the default reset vector `RESET_PC_DEF`.
- Sub-module `fetch_skid_buffer` is natural: the one-entry buffer plus the IF/ID register with stall/flush/bubble logic. The top level keeps the PC, redirect latch and FSM.

## Test plan
- Reset release, zero-wait memory returning `instRdata`=addr → `instAddr` `BFC00000`, `BFC00004`, `BFC00008` on consecutive cycles; `ifidPc` follows one cycle later with `ifidValid`=1.
- Redirect to `80001000` while the delay slot at `BFC00008` is awaiting 3-cycle memory → `BFC00008` is delivered, then the next `instAddr`=`80001000`.
- `stall` high 3 cycles while a word returns → IF/ID holds, `instReq`=0 in HOLD, and the buffered word appears on the first cycle `stall` drops; no word is lost or duplicated.
- `flushValid` (`flushPc`=`BFC00380`) with a request outstanding, data 2 cycles later → returned word dropped, `ifidValid`=0, next request `BFC00380`.
- Flush and `redirectValid` asserted together → `flushPc` wins.
- With `FETCH_ALIGN_CHECK_EN`, redirect to `80001002` → no request, `ifidAdel`=1, `ifidInst`=0; fetching resumes only after a flush to `BFC00380`.
